// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the external combinational ALU: fetches operands from a local
// register file, executes for one cycle, writes back and holds a response until taken.
module alu_cmd_sequencer #(
    parameter  int DATA_W  = 8,
    parameter  int REG_NUM = 8,
    localparam int ADDR_W  = $clog2(REG_NUM)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [3:0]        i_cmd_op,
    input  logic [ADDR_W-1:0] i_cmd_rd,
    input  logic [ADDR_W-1:0] i_cmd_rs1,
    input  logic [ADDR_W-1:0] i_cmd_rs2,
    input  logic [DATA_W-1:0] i_cmd_imm,
    output logic [3:0]        o_alu_ctrl,
    output logic [DATA_W-1:0] o_alu_x,
    output logic [DATA_W-1:0] o_alu_y,
    input  logic [DATA_W-1:0] i_alu_out,
    input  logic              i_alu_carry,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_carry,
    output logic [ADDR_W-1:0] o_rsp_rd,
    output logic              o_rsp_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    localparam logic [3:0] OP_LAST_ALU = 4'hC;
    localparam logic [3:0] OP_LOADI    = 4'hF;

    state_t            r_state;
    state_t            w_next_state;
    logic              w_cmd_fire;
    logic              w_op_alu;
    logic              w_op_loadi;

    logic [3:0]        r_op;
    logic [ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_regs [REG_NUM];

    logic              r_cmd_ready;
    logic [3:0]        r_alu_ctrl;
    logic [DATA_W-1:0] r_alu_x;
    logic [DATA_W-1:0] r_alu_y;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_carry;
    logic [ADDR_W-1:0] r_rsp_rd;
    logic              r_rsp_err;

    // r_cmd_ready is high only in IDLE, so a fire is always an IDLE acceptance.
    assign w_cmd_fire = i_cmd_valid && r_cmd_ready;
    assign w_op_alu   = (r_op <= OP_LAST_ALU);
    assign w_op_loadi = (r_op == OP_LOADI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (w_cmd_fire) w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_RESP;
            S_RESP:  if (i_rsp_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: the register file sits in the reset branch because it must read as zero after reset;
    // plain storage arrays are normally left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_regs[i] <= '0;
            end
            r_op        <= '0;
            r_rd        <= '0;
            r_imm       <= '0;
            r_cmd_ready <= 1'b0;
            r_alu_ctrl  <= '0;
            r_alu_x     <= '0;
            r_alu_y     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_carry <= 1'b0;
            r_rsp_rd    <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            // Handshake flags track the state being entered so they line up with it.
            r_cmd_ready <= (w_next_state == S_IDLE);
            r_rsp_valid <= (w_next_state == S_RESP);

            if (w_cmd_fire) begin
                r_op       <= i_cmd_op;
                r_rd       <= i_cmd_rd;
                r_imm      <= i_cmd_imm;
                r_alu_ctrl <= i_cmd_op;
                r_alu_x    <= r_regs[i_cmd_rs1];
                r_alu_y    <= r_regs[i_cmd_rs2];
            end

            if (r_state == S_EXEC) begin
                r_rsp_rd <= r_rd;
                if (w_op_alu) begin
                    r_regs[r_rd] <= i_alu_out;
                    r_rsp_data   <= i_alu_out;
                    r_rsp_carry  <= i_alu_carry;
                    r_rsp_err    <= 1'b0;
                end else if (w_op_loadi) begin
                    r_regs[r_rd] <= r_imm;
                    r_rsp_data   <= r_imm;
                    r_rsp_carry  <= 1'b0;
                    r_rsp_err    <= 1'b0;
                end else begin
                    r_rsp_data   <= '0;
                    r_rsp_carry  <= 1'b0;
                    r_rsp_err    <= 1'b1;
                end
            end
        end
    end

    assign o_cmd_ready = r_cmd_ready;
    assign o_alu_ctrl  = r_alu_ctrl;
    assign o_alu_x     = r_alu_x;
    assign o_alu_y     = r_alu_y;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_carry = r_rsp_carry;
    assign o_rsp_rd    = r_rsp_rd;
    assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: behavioural ALU on the alu_* ports,
// directed scenarios followed by randomized commands against a register-file model.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [2:0] cmd_rd;
    logic [2:0] cmd_rs1;
    logic [2:0] cmd_rs2;
    logic [7:0] cmd_imm;
    logic [3:0] alu_ctrl;
    logic [7:0] alu_x;
    logic [7:0] alu_y;
    logic [7:0] alu_out;
    logic       alu_carry;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_carry;
    logic [2:0] rsp_rd;
    logic       rsp_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int accept_cyc;
    int hs_cyc;
    int saved_hs;

    logic [7:0] m_regs [8];
    logic [7:0] got;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_cmd_sequencer #(.DATA_W(8), .REG_NUM(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_op    (cmd_op),
        .i_cmd_rd    (cmd_rd),
        .i_cmd_rs1   (cmd_rs1),
        .i_cmd_rs2   (cmd_rs2),
        .i_cmd_imm   (cmd_imm),
        .o_alu_ctrl  (alu_ctrl),
        .o_alu_x     (alu_x),
        .o_alu_y     (alu_y),
        .i_alu_out   (alu_out),
        .i_alu_carry (alu_carry),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rsp_data),
        .o_rsp_carry (rsp_carry),
        .o_rsp_rd    (rsp_rd),
        .o_rsp_err   (rsp_err)
    );

    // Behavioural ALU; carry is a borrow for subtract/decrement.
    function automatic logic [8:0] alu_fn(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y);
        case (c)
            4'h0: return {1'b0, x} + {1'b0, y};
            4'h1: return {x < y, 8'(x - y)};
            4'h2: return {1'b0, x & y};
            4'h3: return {1'b0, x | y};
            4'h4: return {1'b0, ~x};
            4'h5: return {1'b0, x ^ y};
            4'h6: return {1'b0, x} + 9'd1;
            4'h7: return {1'b0, 8'(y << x[2:0])};
            4'h8: return {1'b0, 8'(y >> x[2:0])};
            4'h9: return {x == 8'h00, 8'(x - 8'd1)};
            4'hA: return {1'b0, ~(x & y)};
            4'hB: return {1'b0, y};
            4'hC: return {8'h00, x == y};
            default: return 9'h000;
        endcase
    endfunction

    assign {alu_carry, alu_out} = alu_fn(alu_ctrl, alu_x, alu_y);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_alu_ctrl"},  alu_ctrl,  0);
        check({tag, "_alu_x"},     alu_x,     0);
        check({tag, "_alu_y"},     alu_y,     0);
        check({tag, "_rsp_data"},  rsp_data,  0);
        check({tag, "_rsp_carry"}, rsp_carry, 0);
        check({tag, "_rsp_rd"},    rsp_rd,    0);
        check({tag, "_rsp_err"},   rsp_err,   0);
    endtask

    // One full command: acceptance, EXEC, RESP held for 'stall' extra cycles, handshake.
    task automatic do_cmd(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                          input logic [2:0] rs2, input logic [7:0] imm, input int stall,
                          input bit keep_valid, output logic [7:0] obs);
        logic [8:0] r;
        logic [7:0] e_data;
        logic       e_carry;
        logic       e_err;
        int         t;
        cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
        cmd_valid = 1'b1;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("accept_wait", cmd_ready, 1);
        if (cmd_ready !== 1'b1) begin
            cmd_valid = 1'b0;
            obs = '0;
            return;
        end
        @(posedge clk); #1;
        accept_cyc = cyc;
        if (!keep_valid) cmd_valid = 1'b0;
        check("exec_alu_ctrl",  alu_ctrl,  op);
        check("exec_alu_x",     alu_x,     m_regs[rs1]);
        check("exec_alu_y",     alu_y,     m_regs[rs2]);
        check("exec_cmd_ready", cmd_ready, 0);
        check("exec_rsp_valid", rsp_valid, 0);

        r = alu_fn(op, m_regs[rs1], m_regs[rs2]);
        if (op <= 4'hC) begin
            e_data = r[7:0]; e_carry = r[8]; e_err = 1'b0;
            m_regs[rd] = r[7:0];
        end else if (op == 4'hF) begin
            e_data = imm; e_carry = 1'b0; e_err = 1'b0;
            m_regs[rd] = imm;
        end else begin
            e_data = 8'h00; e_carry = 1'b0; e_err = 1'b1;
        end

        rsp_ready = (stall == 0);
        @(posedge clk); #1;
        check("resp_valid",     rsp_valid, 1);
        check("resp_data",      rsp_data,  e_data);
        check("resp_carry",     rsp_carry, e_carry);
        check("resp_rd",        rsp_rd,    rd);
        check("resp_err",       rsp_err,   e_err);
        check("resp_cmd_ready", cmd_ready, 0);
        obs = rsp_data;
        repeat (stall) begin
            @(posedge clk); #1;
            check("stall_valid",     rsp_valid, 1);
            check("stall_data",      rsp_data,  e_data);
            check("stall_carry",     rsp_carry, e_carry);
            check("stall_err",       rsp_err,   e_err);
            check("stall_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        hs_cyc = cyc;
        rsp_ready = 1'b0;
        check("post_hs_valid",     rsp_valid, 0);
        check("post_hs_cmd_ready", cmd_ready, 1);
        check("post_hs_data_kept", rsp_data,  e_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm = '0;
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_cmd_ready", cmd_ready, 1);
        check("idle_rsp_valid", rsp_valid, 0);

        // LOADI and ADD
        do_cmd(4'hF, 3'd1, 3'd0, 3'd0, 8'h05, 0, 0, got);
        check("loadi_r1", got, 8'h05);
        do_cmd(4'hF, 3'd2, 3'd0, 3'd0, 8'h03, 0, 0, got);
        check("loadi_r2", got, 8'h03);
        do_cmd(4'h0, 3'd3, 3'd1, 3'd2, 8'h00, 0, 0, got);
        check("add_data", got, 8'h08);
        check("add_carry", rsp_carry, 0);

        // SUB with borrow, then compare of a register with itself
        do_cmd(4'h1, 3'd4, 3'd2, 3'd1, 8'h00, 0, 0, got);
        check("sub_data", got, 8'hFE);
        check("sub_carry", rsp_carry, 1);
        do_cmd(4'hC, 3'd5, 3'd1, 3'd1, 8'h00, 0, 0, got);
        check("cmp_data", got, 8'h01);

        // Dependent chain, rs1 = rd on the second command; rs2 reads R3
        do_cmd(4'h7, 3'd6, 3'd2, 3'd1, 8'h00, 0, 0, got);
        check("shl_data", got, 8'h28);
        do_cmd(4'h4, 3'd6, 3'd6, 3'd3, 8'h00, 0, 0, got);
        check("not_data", got, 8'hD7);
        check("r3_readback", alu_y, 8'h08);

        // Backpressure with cmd_valid held through RESP
        do_cmd(4'h0, 3'd0, 3'd3, 3'd4, 8'h00, 5, 1, got);
        check("bp_data", got, 8'h06);
        saved_hs = hs_cyc;
        do_cmd(4'h0, 3'd0, 3'd3, 3'd4, 8'h00, 0, 0, got);
        check("bp_next_accept", accept_cyc, saved_hs + 1);

        // Illegal opcodes: no writeback
        do_cmd(4'hD, 3'd1, 3'd0, 3'd0, 8'h77, 0, 0, got);
        check("illegal_data", got, 8'h00);
        check("illegal_err", rsp_err, 1);
        do_cmd(4'hE, 3'd2, 3'd1, 3'd2, 8'h00, 1, 0, got);
        check("r1_unchanged", alu_x, 8'h05);
        check("r2_unchanged", alu_y, 8'h03);

        // Randomized commands including LOADI, illegal ops and backpressure
        for (int i = 0; i < 40; i++) begin
            do_cmd(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   3'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 3), 0, got);
        end

        // Reset during EXEC discards the command and clears the register file
        do_cmd(4'hF, 3'd7, 3'd0, 3'd0, 8'hAA, 0, 0, got);
        check("loadi_r7", got, 8'hAA);
        cmd_op = 4'h0; cmd_rd = 3'd7; cmd_rs1 = 3'd7; cmd_rs2 = 3'd7;
        cmd_valid = 1'b1;
        @(posedge clk); #2;
        check("pre_rst_alu_x", alu_x, 8'hAA);
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        #1;
        check_outputs_zero("midrst");
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("after_rst_cmd_ready", cmd_ready, 1);
        check("after_rst_rsp_valid", rsp_valid, 0);
        do_cmd(4'h0, 3'd0, 3'd7, 3'd1, 8'h00, 0, 0, got);
        check("r7_cleared", alu_x, 8'h00);
        check("r1_cleared", alu_y, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
